// File: rtl/sine_arg_reduce.sv
// Reduces an unsigned Q8.8 angle modulo 2*pi, folds into [0, pi/2], emits Q4.8 argument plus negate flag.
// Latency: result valid STEPS+1 clocks after acceptance; one operation in flight.
// Backpressure: result held until x_rdy_i; arg_rdy_o low from acceptance until the result is taken.
module sine_arg_reduce #(
    parameter int unsigned     IN_W    = 16,
    parameter int unsigned     OUT_W   = 12,
    parameter logic [IN_W-1:0] TWO_PI  = 16'd1608,
    parameter logic [IN_W-1:0] PI      = 16'd804,
    parameter logic [IN_W-1:0] HALF_PI = 16'd402,
    parameter int unsigned     STEPS   = 6
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [IN_W-1:0]  angle_i,
    input  logic             arg_vld_i,
    output logic             arg_rdy_o,
    output logic [OUT_W-1:0] x_o,
    output logic             neg_o,
    output logic             x_vld_o,
    input  logic             x_rdy_i
);

    localparam int unsigned K_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        FOLD   = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  r_q, r_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [OUT_W-1:0] x_q, x_d;
    logic             neg_q, neg_d;
    logic             x_vld_q, x_vld_d;

    logic [IN_W:0]    sub_w;
    logic [IN_W-1:0]  fold_h;
    logic [IN_W-1:0]  fold_x;
    logic             fold_neg;

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        k_d      = k_q;
        x_d      = x_q;
        neg_d    = neg_q;
        x_vld_d  = x_vld_q;

        // One extra bit so the largest shifted modulus never wraps in the compare.
        sub_w    = {1'b0, TWO_PI} << k_q;

        // Fold r (< 2*pi) into [0, pi/2]; the upper half-turn maps onto a negated sine.
        fold_neg = (r_q >= PI);
        fold_h   = fold_neg ? (r_q - PI) : r_q;
        fold_x   = (fold_h <= HALF_PI) ? fold_h : (PI - fold_h);

        case (state_q)
            IDLE: begin
                if (arg_vld_i) begin
                    r_d     = angle_i;
                    k_d     = K_W'(STEPS - 1);
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if ({1'b0, r_q} >= sub_w) begin
                    r_d = r_q - sub_w[IN_W-1:0];
                end
                if (k_q == '0) begin
                    state_d = FOLD;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            FOLD: begin
                x_d     = OUT_W'(fold_x);
                neg_d   = fold_neg;
                x_vld_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (x_rdy_i) begin
                    x_vld_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            r_q     <= '0;
            k_q     <= '0;
            x_q     <= '0;
            neg_q   <= 1'b0;
            x_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
            x_q     <= x_d;
            neg_q   <= neg_d;
            x_vld_q <= x_vld_d;
        end
    end

    assign arg_rdy_o = (state_q == IDLE);
    assign x_o       = x_q;
    assign neg_o     = neg_q;
    assign x_vld_o   = x_vld_q;

endmodule

// File: tb/tb_sine_arg_reduce.sv
// Directed and random angles against an arithmetic modulo/fold model of sine_arg_reduce.
module tb_sine_arg_reduce;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic [15:0] angle_i = '0;
    logic        arg_vld_i = 1'b0;
    logic        arg_rdy_o;
    logic [11:0] x_o;
    logic        neg_o;
    logic        x_vld_o;
    logic        x_rdy_i = 1'b1;

    int tests = 0;
    int fails = 0;

    sine_arg_reduce dut (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .angle_i   (angle_i),
        .arg_vld_i (arg_vld_i),
        .arg_rdy_o (arg_rdy_o),
        .x_o       (x_o),
        .neg_o     (neg_o),
        .x_vld_o   (x_vld_o),
        .x_rdy_i   (x_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer modulo 2*pi, then half-turn and quarter-turn symmetry.
    task automatic model(input int ang, output int ex, output int en);
        int r, h;
        r  = ang % 1608;
        en = (r >= 804) ? 1 : 0;
        h  = en ? r - 804 : r;
        ex = (h <= 402) ? h : 804 - h;
    endtask

    task automatic do_op(input logic [15:0] ang, input int hold, input bit pulse);
        int n, ex, en;
        model(int'(ang), ex, en);
        n = 0;
        while (!arg_rdy_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("rdy_idle", 32'(arg_rdy_o), 1);
        angle_i   = ang;
        arg_vld_i = 1'b1;
        x_rdy_i   = (hold == 0);
        @(negedge clk_i);
        arg_vld_i = 1'b0;
        angle_i   = 16'($urandom);
        check("rdy_busy", 32'(arg_rdy_o), 0);
        n = 0;
        while (!x_vld_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("latency", 32'(n), 7);
        check("x", 32'(x_o), 32'(ex));
        check("neg", 32'(neg_o), 32'(en));
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                angle_i   = 16'd1000;
                arg_vld_i = 1'b1;
            end
            @(negedge clk_i);
            arg_vld_i = 1'b0;
            check("hold_vld", 32'(x_vld_o), 1);
            check("hold_x", 32'(x_o), 32'(ex));
            check("hold_neg", 32'(neg_o), 32'(en));
            check("hold_rdy", 32'(arg_rdy_o), 0);
        end
        x_rdy_i = 1'b1;
        @(negedge clk_i);
        check("vld_drop", 32'(x_vld_o), 0);
        check("rdy_back", 32'(arg_rdy_o), 1);
        check("x_kept", 32'(x_o), 32'(ex));
        if (pulse) begin
            repeat (3) begin
                @(negedge clk_i);
                check("ignored_pulse_rdy", 32'(arg_rdy_o), 1);
                check("ignored_pulse_vld", 32'(x_vld_o), 0);
            end
        end
    endtask

    initial begin
        #1;
        check("rst_rdy", 32'(arg_rdy_o), 1);
        check("rst_vld", 32'(x_vld_o), 0);
        check("rst_x", 32'(x_o), 0);
        check("rst_neg", 32'(neg_o), 0);
        @(negedge clk_i);
        srst_i = 1'b0;
        @(negedge clk_i);

        do_op(16'h0180, 0, 1'b0);
        check("plan_1p5", 32'(x_o), 384);
        do_op(16'h0640, 0, 1'b0);
        do_op(16'h0280, 0, 1'b0);
        do_op(16'hFFFF, 0, 1'b0);
        check("plan_ffff", 32'(x_o), 393);
        do_op(16'd1608, 0, 1'b0);
        do_op(16'd804, 0, 1'b0);
        do_op(16'd402, 0, 1'b0);
        do_op(16'd1206, 0, 1'b0);
        do_op(16'd0, 0, 1'b0);
        do_op(16'd64320, 0, 1'b0);
        do_op(16'd1607, 2, 1'b0);

        do_op(16'h0640, 5, 1'b1);

        // Asynchronous reset between edges while reducing.
        angle_i   = 16'h0280;
        arg_vld_i = 1'b1;
        @(negedge clk_i);
        arg_vld_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #2;
        srst_i = 1'b1;
        #1;
        check("arst_rdy", 32'(arg_rdy_o), 1);
        check("arst_vld", 32'(x_vld_o), 0);
        check("arst_x", 32'(x_o), 0);
        check("arst_neg", 32'(neg_o), 0);
        @(negedge clk_i);
        srst_i = 1'b0;
        repeat (10) begin
            @(negedge clk_i);
            check("arst_no_out", 32'(x_vld_o), 0);
        end
        do_op(16'h0280, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            do_op(16'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
